// File: rtl/rgb_capture.sv
// RGB pixel capture: packs incoming video into 16-bit words and writes
// complete slices into a ring of IMAGES_IN_RAM slots in external RAM.
module rgb_capture #(
    parameter int IMG_W                = 80,
    parameter int IMG_H                = 48,
    parameter int IMAGES_IN_RAM        = 3,
    parameter int SLICES_BEFORE_STREAM = 1,
    parameter int RAM_ADDR_WIDTH       = 32,
    localparam int SLOT_W = (IMAGES_IN_RAM > 1) ? $clog2(IMAGES_IN_RAM) : 1
) (
    input  logic                      rgb_clk,
    input  logic                      rst,
    input  logic [23:0]               rgb,
    input  logic                      hsync,
    input  logic                      vsync,
    input  logic [1:0]                fmt,
    input  logic                      rgb_enable,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]               ram_data,
    output logic                      write_enable,
    output logic                      stream_ready,
    output logic                      frame_done,
    output logic                      frame_error,
    output logic [SLOT_W-1:0]         last_slot
);

    localparam int IMAGE_SIZE = IMG_W * IMG_H;
    localparam int CNT_W      = $clog2(IMAGE_SIZE + 2);
    localparam int DONE_W     = $clog2(SLICES_BEFORE_STREAM + 1);

    localparam logic [CNT_W-1:0]          CNT_FULL   = CNT_W'(IMAGE_SIZE);
    localparam logic [CNT_W-1:0]          CNT_OVF    = CNT_W'(IMAGE_SIZE + 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] SLICE_STEP = RAM_ADDR_WIDTH'(IMAGE_SIZE);
    localparam logic [SLOT_W-1:0]         SLOT_MAX   = SLOT_W'(IMAGES_IN_RAM - 1);
    localparam logic [DONE_W-1:0]         DONE_MAX   = DONE_W'(SLICES_BEFORE_STREAM);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE
    } state_t;

    state_t                    state_q;
    logic [15:0]               pix_q;
    logic                      hs_q;
    logic                      vs_q;
    logic                      vs_prev_q;
    logic [1:0]                vs_valid_q;
    logic [1:0]                fmt_q;

    logic [CNT_W-1:0]          pix_cnt_q;
    logic                      ovf_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [RAM_ADDR_WIDTH-1:0] base_q;
    logic [DONE_W-1:0]         done_cnt_q;

    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
    logic [15:0]               ram_data_q;
    logic                      write_enable_q;
    logic                      stream_ready_q;
    logic                      frame_done_q;
    logic                      frame_error_q;
    logic [SLOT_W-1:0]         last_slot_q;

    logic [15:0]               packed_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_d;
    logic                      pixel_active;
    logic                      vs_rise;
    logic                      vs_fall;
    logic                      unused_rgb_lsbs;

    // Colour LSBs below the widest packing are truncated away.
    assign unused_rgb_lsbs = ^{rgb[18:16], rgb[9:8], rgb[2:0]};

    // Input stage keeps only the RGB565 bits; narrower formats are subsets.
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            pix_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            vs_prev_q  <= 1'b0;
            vs_valid_q <= '0;
            fmt_q      <= '0;
        end else begin
            pix_q      <= {rgb[23:19], rgb[15:10], rgb[7:3]};
            hs_q       <= hsync;
            vs_q       <= vsync;
            vs_prev_q  <= vs_q;
            vs_valid_q <= {vs_valid_q[0], 1'b1};
            fmt_q      <= fmt;
        end
    end

    always_comb begin
        case (fmt_q)
            2'b01:   packed_d = {1'b0, pix_q[15:11], pix_q[10:6], pix_q[4:0]};
            2'b10:   packed_d = {4'b0, pix_q[15:12], pix_q[10:7], pix_q[4:1]};
            default: packed_d = pix_q;
        endcase
    end

    // A rise is only trusted once vs_prev_q holds a real sample, so a reset
    // in the middle of a frame cannot be mistaken for a start of frame.
    assign pixel_active = hs_q & vs_q;
    assign vs_rise      = vs_q & ~vs_prev_q & vs_valid_q[1];
    assign vs_fall      = ~vs_q & vs_prev_q;
    assign addr_d       = base_q + RAM_ADDR_WIDTH'(pix_cnt_q);

    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pix_cnt_q      <= '0;
            ovf_q          <= 1'b0;
            slot_q         <= '0;
            base_q         <= '0;
            done_cnt_q     <= '0;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            write_enable_q <= 1'b0;
            stream_ready_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            last_slot_q    <= '0;
        end else begin
            write_enable_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rgb_enable) begin
                        state_q <= WAIT_SOF;
                    end
                end

                WAIT_SOF: begin
                    if (vs_rise) begin
                        state_q <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (vs_fall) begin
                        pix_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                        if (pix_cnt_q == CNT_FULL && !ovf_q) begin
                            frame_done_q <= 1'b1;
                            last_slot_q  <= slot_q;
                            if (slot_q == SLOT_MAX) begin
                                slot_q <= '0;
                                base_q <= '0;
                            end else begin
                                slot_q <= slot_q + SLOT_W'(1);
                                base_q <= base_q + SLICE_STEP;
                            end
                            if (done_cnt_q != DONE_MAX) begin
                                done_cnt_q <= done_cnt_q + DONE_W'(1);
                            end
                            if (done_cnt_q >= DONE_MAX - DONE_W'(1)) begin
                                stream_ready_q <= 1'b1;
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end else if (pixel_active) begin
                        if (pix_cnt_q < CNT_FULL) begin
                            write_enable_q <= 1'b1;
                            ram_addr_q     <= addr_d;
                            ram_data_q     <= packed_d;
                            pix_cnt_q      <= pix_cnt_q + CNT_W'(1);
                        end else begin
                            ovf_q     <= 1'b1;
                            pix_cnt_q <= CNT_OVF;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase

            // Disable wins over everything above except the end-of-slice
            // pulses and last_slot, which were already committed this edge.
            if (!rgb_enable) begin
                state_q        <= IDLE;
                pix_cnt_q      <= '0;
                ovf_q          <= 1'b0;
                slot_q         <= '0;
                base_q         <= '0;
                done_cnt_q     <= '0;
                stream_ready_q <= 1'b0;
                write_enable_q <= 1'b0;
            end
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign write_enable = write_enable_q;
    assign stream_ready = stream_ready_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;
    assign last_slot    = last_slot_q;

endmodule

// File: tb/tb_rgb_capture.sv
// Directed self-checking bench for rgb_capture with a 4x2 slice, 3-slot ring
// and two slices required before streaming.
module tb_rgb_capture;

    logic        rgb_clk;
    logic        rst;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic [1:0]  fmt;
    logic        rgb_enable;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        write_enable;
    logic        stream_ready;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  last_slot;

    rgb_capture #(
        .IMG_W(4),
        .IMG_H(2),
        .IMAGES_IN_RAM(3),
        .SLICES_BEFORE_STREAM(2),
        .RAM_ADDR_WIDTH(8)
    ) dut (
        .rgb_clk(rgb_clk),
        .rst(rst),
        .rgb(rgb),
        .hsync(hsync),
        .vsync(vsync),
        .fmt(fmt),
        .rgb_enable(rgb_enable),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .write_enable(write_enable),
        .stream_ready(stream_ready),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .last_slot(last_slot)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    int total = 0;
    int bad   = 0;

    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          n_done;
    int          n_err;

    // Passive recorder of every registered output event.
    always @(negedge rgb_clk) begin
        if (write_enable === 1'b1) begin
            wr_addr.push_back(int'(ram_addr));
            wr_data.push_back(ram_data);
        end
        if (frame_done === 1'b1) n_done++;
        if (frame_error === 1'b1) n_err++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rgb_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    function automatic logic [23:0] pix(input int s, input int i);
        pix = {8'(s * 40 + i * 17), 8'(i * 29 + 5), 8'(200 - i * 13)};
    endfunction

    function automatic logic [15:0] exp565(input logic [23:0] c);
        exp565 = {c[23:19], c[15:10], c[7:3]};
    endfunction

    task automatic drive_pixels(input int s, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (i % 4 == 0 && i > 0) begin
                hsync = 1'b0;
                step(1);
            end
            hsync = 1'b1;
            rgb   = pix(s, i);
            step(1);
        end
        hsync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rgb = '0; hsync = 1'b0; vsync = 1'b0; fmt = 2'b00; rgb_enable = 1'b0;
        step(2);
        total++; if (ram_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got %0h want 0", ram_addr); end
        total++; if (ram_data !== 16'd0) begin bad++; $display("FAIL reset_data got %0h want 0", ram_data); end
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", write_enable); end
        total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL reset_sr got %b want 0", stream_ready); end
        total++; if ({frame_done, frame_error} !== 2'b00) begin bad++; $display("FAIL reset_pulses got %b%b want 00", frame_done, frame_error); end
        total++; if (last_slot !== 2'd0) begin bad++; $display("FAIL reset_last_slot got %0d want 0", last_slot); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_frame(input string nm, input int s, input int npix, input int base,
                              input int nwr, input int e_done, input int e_err,
                              input int e_slot, input logic e_sr);
        clear_mon();
        vsync = 1'b1;
        hsync = 1'b0;
        step(3);
        drive_pixels(s, npix);
        step(2);
        vsync = 1'b0;
        step(5);
        total++;
        if (wr_addr.size() != nwr) begin
            bad++; $display("FAIL %s nwrites got %0d want %0d", nm, wr_addr.size(), nwr);
        end
        for (int i = 0; i < nwr && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] != base + i) begin
                bad++; $display("FAIL %s addr[%0d] got %0d want %0d", nm, i, wr_addr[i], base + i);
            end
            total++;
            if (wr_data[i] !== exp565(pix(s, i))) begin
                bad++; $display("FAIL %s data[%0d] got %h want %h", nm, i, wr_data[i], exp565(pix(s, i)));
            end
        end
        total++; if (n_done != e_done) begin bad++; $display("FAIL %s frame_done got %0d want %0d", nm, n_done, e_done); end
        total++; if (n_err != e_err) begin bad++; $display("FAIL %s frame_error got %0d want %0d", nm, n_err, e_err); end
        total++; if (last_slot !== 2'(e_slot)) begin bad++; $display("FAIL %s last_slot got %0d want %0d", nm, last_slot, e_slot); end
        total++; if (stream_ready !== e_sr) begin bad++; $display("FAIL %s stream_ready got %b want %b", nm, stream_ready, e_sr); end
    endtask

    task automatic test_enable_midframe();
        clear_mon();
        vsync = 1'b1;
        hsync = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) rgb_enable = 1'b1;
            rgb = pix(99, i);
            step(1);
        end
        hsync = 1'b0;
        step(1);
        vsync = 1'b0;
        step(5);
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL midframe_writes got %0d want 0", wr_addr.size()); end
        total++; if (n_done + n_err != 0) begin bad++; $display("FAIL midframe_pulses got %0d want 0", n_done + n_err); end
        test_frame("first", 1, 8, 0, 8, 1, 0, 0, 1'b0);
        test_frame("second", 2, 8, 8, 8, 1, 0, 1, 1'b1);
    endtask

    task automatic test_wrap();
        test_frame("third", 3, 8, 16, 8, 1, 0, 2, 1'b1);
        test_frame("wrap", 4, 8, 0, 8, 1, 0, 0, 1'b1);
    endtask

    task automatic test_short();
        test_frame("slot1", 5, 8, 8, 8, 1, 0, 1, 1'b1);
        test_frame("short", 6, 6, 16, 6, 0, 1, 1, 1'b1);
        test_frame("rewrite", 7, 8, 16, 8, 1, 0, 2, 1'b1);
    endtask

    task automatic test_overflow();
        test_frame("overflow", 8, 10, 0, 8, 0, 1, 2, 1'b1);
        test_frame("after_ovf", 9, 8, 0, 8, 1, 0, 0, 1'b1);
    endtask

    task automatic test_fmt();
        logic [1:0]  fmts [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic [15:0] exps [4] = '{16'h0FA5, 16'h7EAA, 16'hFD4A, 16'hFD4A};
        for (int f = 0; f < 4; f++) begin
            clear_mon();
            fmt   = fmts[f];
            rgb   = 24'hFFAA55;
            vsync = 1'b1;
            step(3);
            hsync = 1'b1;
            step(8);
            hsync = 1'b0;
            step(2);
            vsync = 1'b0;
            step(5);
            total++;
            if (wr_data.size() != 8) begin
                bad++; $display("FAIL fmt%0d nwrites got %0d want 8", fmts[f], wr_data.size());
            end else begin
                total++;
                if (wr_data[7] !== exps[f]) begin
                    bad++; $display("FAIL fmt%0d data got %h want %h", fmts[f], wr_data[7], exps[f]);
                end
            end
        end
        fmt = 2'b00;
    endtask

    task automatic test_enable_drop();
        int we_seen;
        vsync = 1'b1;
        step(3);
        hsync = 1'b1;
        rgb   = pix(10, 0);
        step(3);
        rgb_enable = 1'b0;
        step(1);
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL drop_we got %b want 0", write_enable); end
        total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL drop_sr got %b want 0", stream_ready); end
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (write_enable !== 1'b0) we_seen++;
        end
        total++; if (we_seen != 0) begin bad++; $display("FAIL drop_late_we got %0d want 0", we_seen); end
        total++; if (last_slot !== 2'd1) begin bad++; $display("FAIL drop_last_slot got %0d want 1", last_slot); end
        hsync = 1'b0;
        vsync = 1'b0;
        step(4);
        rgb_enable = 1'b1;
        step(2);
        test_frame("reenable", 11, 8, 0, 8, 1, 0, 0, 1'b0);
        test_frame("reenable2", 12, 8, 8, 8, 1, 0, 1, 1'b1);
    endtask

    task automatic test_reset_midframe();
        vsync = 1'b1;
        step(3);
        hsync = 1'b1;
        rgb   = pix(13, 0);
        step(3);
        rst = 1'b1;
        step(1);
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_we got %b want 0", write_enable); end
        total++; if (stream_ready !== 1'b0) begin bad++; $display("FAIL rstmid_sr got %b want 0", stream_ready); end
        total++; if (last_slot !== 2'd0) begin bad++; $display("FAIL rstmid_last_slot got %0d want 0", last_slot); end
        rst = 1'b0;
        clear_mon();
        step(4);
        hsync = 1'b0;
        step(1);
        vsync = 1'b0;
        step(5);
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL rstmid_writes got %0d want 0", wr_addr.size()); end
        total++; if (n_done + n_err != 0) begin bad++; $display("FAIL rstmid_pulses got %0d want 0", n_done + n_err); end
        test_frame("after_rst", 14, 8, 0, 8, 1, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_enable_midframe();
        test_wrap();
        test_short();
        test_overflow();
        test_fmt();
        test_enable_drop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before end of sequence");
        $fatal(1, "timeout");
    end

endmodule
